// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: shared constants for the Basys 3 seven-segment loopback path.
//   - active-low segment codes for digits 0..9 (bit 6 = segment A, bit 0 = segment G)
//   - active-low anode select codes for AN0..AN3 plus the all-dark code
//   - digit count, BCD digit type and a BCD-to-binary helper
package seven_seg_pkg;

   localparam int unsigned NUM_DIGITS = 4;

   typedef logic [3:0] bcd_t;

   localparam logic [6:0] ZERO  = 7'b0000001;
   localparam logic [6:0] ONE   = 7'b1001111;
   localparam logic [6:0] TWO   = 7'b0010010;
   localparam logic [6:0] THREE = 7'b0000110;
   localparam logic [6:0] FOUR  = 7'b1001100;
   localparam logic [6:0] FIVE  = 7'b0100100;
   localparam logic [6:0] SIX   = 7'b0100000;
   localparam logic [6:0] SEVEN = 7'b0001111;
   localparam logic [6:0] EIGHT = 7'b0000000;
   localparam logic [6:0] NINE  = 7'b0000100;

   localparam logic [3:0] AN0_SEL  = 4'b1110;
   localparam logic [3:0] AN1_SEL  = 4'b1101;
   localparam logic [3:0] AN2_SEL  = 4'b1011;
   localparam logic [3:0] AN3_SEL  = 4'b0111;
   localparam logic [3:0] AN_BLANK = 4'b1111;

   // {d3, d2, d1, d0} -> d3*1000 + d2*100 + d1*10 + d0; 14 bits covers 9999.
   function automatic logic [13:0] bcd_to_bin(input logic [15:0] bcd);
      logic [13:0] d3, d2, d1, d0;
      d3 = {10'd0, bcd[15:12]};
      d2 = {10'd0, bcd[11:8]};
      d1 = {10'd0, bcd[7:4]};
      d0 = {10'd0, bcd[3:0]};
      return (d3 * 14'd1000) + (d2 * 14'd100) + (d1 * 14'd10) + d0;
   endfunction

endpackage

// File: rtl/seven_seg_decode.sv
// seven_seg_decode: combinational active-low segment pattern to BCD digit.
//   seg     in  7  active-low cathodes, bit 6 = A .. bit 0 = G
//   digit   out 4  decoded digit (0 when illegal)
//   illegal out 1  pattern is not one of the ten digit codes
module seven_seg_decode
   import seven_seg_pkg::*;
(
   input  logic [6:0] seg,
   output bcd_t       digit,
   output logic       illegal
);

   always_comb begin
      digit   = 4'd0;
      illegal = 1'b0;
      case (seg)
         ZERO:    digit = 4'd0;
         ONE:     digit = 4'd1;
         TWO:     digit = 4'd2;
         THREE:   digit = 4'd3;
         FOUR:    digit = 4'd4;
         FIVE:    digit = 4'd5;
         SIX:     digit = 4'd6;
         SEVEN:   digit = 4'd7;
         EIGHT:   digit = 4'd8;
         NINE:    digit = 4'd9;
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/seven_seg_capture.sv
// seven_seg_capture: loopback decoder for the 4-digit multiplexed seven-segment display.
// Samples anodes/cathodes, captures each pattern once it has been stable, decodes it and
// assembles a full 4-digit frame into a BCD word and its binary value.
//   intClk    in  1   system clock
//   reset     in  1   asynchronous, active-high reset
//   segIn     in  7   active-low cathodes, bit 6 = A .. bit 0 = G
//   anIn      in  4   active-low anodes, bit n = AN n
//   value     out 14  last frame as binary (0..9999)
//   digitsBcd out 16  last frame as BCD {d3, d2, d1, d0}
//   valid     out 1   pulse when value/digitsBcd update
//   segError  out 1   pulse on an illegal captured segment pattern
//   anError   out 1   pulse on an illegal captured anode pattern
//   timeout   out 1   pulse when no frame completed within FRAME_TIMEOUT cycles
// Build option: define SEVEN_SEG_CAPTURE_ONCHANGE_EN to emit only frames whose BCD differs
// from the held one (first frame after reset always emits).
module seven_seg_capture
   import seven_seg_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = 1000,
   parameter int unsigned FRAME_TIMEOUT = 2000000
) (
   input  logic        intClk,
   input  logic        reset,
   input  logic [6:0]  segIn,
   input  logic [3:0]  anIn,
   output logic [13:0] value,
   output logic [15:0] digitsBcd,
   output logic        valid,
   output logic        segError,
   output logic        anError,
   output logic        timeout
);

   localparam int unsigned STAB_W = $clog2(STABLE_CYCLES + 1);
   localparam int unsigned TO_W   = $clog2(FRAME_TIMEOUT);

   localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYCLES);
   localparam logic [STAB_W-1:0] STAB_PRE = STAB_W'(STABLE_CYCLES - 2);
   localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(FRAME_TIMEOUT - 1);

   localparam logic [0:0] COLLECT = 1'b0;
   localparam logic [0:0] EMIT    = 1'b1;

   logic [10:0]       sync1_q, sync2_q, prev_q;
   logic [STAB_W-1:0] stab_q, stab_d;
   logic              capture;

   logic [3:0]        cap_an;
   logic [6:0]        cap_seg;
   bcd_t              cap_digit;
   logic              cap_illegal;
   logic              slot_hit, an_bad;
   logic [1:0]        slot_idx;
   logic              write_evt, seg_err_evt, an_err_evt;

   logic [15:0]       slots_q, slots_d;
   logic [3:0]        mask_q, mask_d;
   logic [0:0]        state_q, state_d;
   logic [TO_W-1:0]   to_q, to_d;
   logic              frame_done, to_fire, emit;

   logic [13:0]       value_q, value_d;
   logic [15:0]       digits_q, digits_d;
   logic              valid_q, seg_err_q, an_err_q, timeout_q;

   // Stability counter: saturates at STABLE_CYCLES so the capture point is hit once per
   // window. Capture fires as the counter steps to STABLE_CYCLES-1.
   always_comb begin
      if (sync2_q != prev_q) begin
         stab_d = '0;
      end else if (stab_q != STAB_MAX) begin
         stab_d = stab_q + 1'b1;
      end else begin
         stab_d = stab_q;
      end
   end

   assign capture = (sync2_q == prev_q) && (stab_q == STAB_PRE);
   assign cap_an  = sync2_q[10:7];
   assign cap_seg = sync2_q[6:0];

   seven_seg_decode u_decode (
      .seg     (cap_seg),
      .digit   (cap_digit),
      .illegal (cap_illegal)
   );

   always_comb begin
      slot_hit = 1'b0;
      slot_idx = 2'd0;
      an_bad   = 1'b0;
      case (cap_an)
         AN0_SEL:  begin slot_hit = 1'b1; slot_idx = 2'd0; end
         AN1_SEL:  begin slot_hit = 1'b1; slot_idx = 2'd1; end
         AN2_SEL:  begin slot_hit = 1'b1; slot_idx = 2'd2; end
         AN3_SEL:  begin slot_hit = 1'b1; slot_idx = 2'd3; end
         AN_BLANK: ;
         default:  an_bad = 1'b1;
      endcase
   end

   // Segment errors only count for a selected digit; a dark display is ignored.
   assign an_err_evt  = capture && an_bad;
   assign seg_err_evt = capture && slot_hit && cap_illegal;
   assign write_evt   = capture && slot_hit && !cap_illegal;

   always_comb begin
      slots_d    = slots_q;
      mask_d     = mask_q;
      state_d    = state_q;
      frame_done = 1'b0;

      if (write_evt) begin
         slots_d[{slot_idx, 2'b00} +: 4] = cap_digit;
         mask_d[slot_idx]                = 1'b1;
      end
      if (an_err_evt || seg_err_evt) begin
         mask_d = '0;
      end

      case (state_q)
         COLLECT: begin
            if (write_evt && (mask_d == 4'b1111)) begin
               frame_done = 1'b1;
               state_d    = EMIT;
            end
         end
         EMIT: begin
            mask_d  = '0;
            state_d = COLLECT;
         end
         default: state_d = COLLECT;
      endcase

      // A completing frame on the same cycle beats the timeout.
      to_fire = (to_q == TO_LAST) && !frame_done;
      if (to_fire) begin
         mask_d = '0;
      end
      if (frame_done || to_fire) begin
         to_d = '0;
      end else begin
         to_d = to_q + 1'b1;
      end
   end

`ifdef SEVEN_SEG_CAPTURE_ONCHANGE_EN
   logic first_q;

   assign emit = frame_done && (first_q || (slots_d != digits_q));

   always_ff @(posedge intClk or posedge reset) begin
      if (reset) begin
         first_q <= 1'b1;
      end else if (frame_done) begin
         first_q <= 1'b0;
      end
   end
`else
   assign emit = frame_done;
`endif

   always_comb begin
      value_d  = value_q;
      digits_d = digits_q;
      if (emit) begin
         digits_d = slots_d;
         value_d  = bcd_to_bin(slots_d);
      end
   end

   always_ff @(posedge intClk or posedge reset) begin
      if (reset) begin
         sync1_q   <= '1;
         sync2_q   <= '1;
         prev_q    <= '1;
         stab_q    <= '0;
         slots_q   <= '0;
         mask_q    <= '0;
         state_q   <= COLLECT;
         to_q      <= '0;
         value_q   <= '0;
         digits_q  <= '0;
         valid_q   <= 1'b0;
         seg_err_q <= 1'b0;
         an_err_q  <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         sync1_q   <= {anIn, segIn};
         sync2_q   <= sync1_q;
         prev_q    <= sync2_q;
         stab_q    <= stab_d;
         slots_q   <= slots_d;
         mask_q    <= mask_d;
         state_q   <= state_d;
         to_q      <= to_d;
         value_q   <= value_d;
         digits_q  <= digits_d;
         valid_q   <= emit;
         seg_err_q <= seg_err_evt;
         an_err_q  <= an_err_evt;
         timeout_q <= to_fire;
      end
   end

   assign value     = value_q;
   assign digitsBcd = digits_q;
   assign valid     = valid_q;
   assign segError  = seg_err_q;
   assign anError   = an_err_q;
   assign timeout   = timeout_q;

endmodule

// File: tb/tb_seven_seg_capture.sv
// tb_seven_seg_capture: directed bench for seven_seg_capture with STABLE_CYCLES = 8 and
// FRAME_TIMEOUT = 400. Pulse outputs are counted on the falling edge; expected values are
// hand-computed constants.
module tb_seven_seg_capture;

   localparam int unsigned STAB = 8;
   localparam int unsigned TMO  = 400;

   localparam logic [6:0] S_DARK = 7'b1111111;
   localparam logic [3:0] A0     = 4'b1110;
   localparam logic [3:0] A1     = 4'b1101;
   localparam logic [3:0] A2     = 4'b1011;
   localparam logic [3:0] A3     = 4'b0111;
   localparam logic [3:0] A_DARK = 4'b1111;
   localparam logic [3:0] A_BAD  = 4'b1100;

`ifdef SEVEN_SEG_CAPTURE_ONCHANGE_EN
   localparam bit ONCHANGE = 1'b1;
`else
   localparam bit ONCHANGE = 1'b0;
`endif

   logic        intClk = 1'b0;
   logic        reset;
   logic [6:0]  segIn;
   logic [3:0]  anIn;
   logic [13:0] value;
   logic [15:0] digitsBcd;
   logic        valid, segError, anError, timeout;

   int checks   = 0;
   int failures = 0;
   int n_valid  = 0;
   int n_seg    = 0;
   int n_an     = 0;
   int n_to     = 0;

   always #5 intClk = ~intClk;

   seven_seg_capture #(
      .STABLE_CYCLES (STAB),
      .FRAME_TIMEOUT (TMO)
   ) dut (
      .intClk    (intClk),
      .reset     (reset),
      .segIn     (segIn),
      .anIn      (anIn),
      .value     (value),
      .digitsBcd (digitsBcd),
      .valid     (valid),
      .segError  (segError),
      .anError   (anError),
      .timeout   (timeout)
   );

   // Pulse counters; each counts cycles high, so a single-cycle pulse adds exactly one.
   always @(negedge intClk) begin
      if (valid === 1'b1)    n_valid <= n_valid + 1;
      if (segError === 1'b1) n_seg   <= n_seg + 1;
      if (anError === 1'b1)  n_an    <= n_an + 1;
      if (timeout === 1'b1)  n_to    <= n_to + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
      end
   endtask

   function automatic logic [6:0] seg_of(input int d);
      case (d)
         0:       return 7'b0000001;
         1:       return 7'b1001111;
         2:       return 7'b0010010;
         3:       return 7'b0000110;
         4:       return 7'b1001100;
         5:       return 7'b0100100;
         6:       return 7'b0100000;
         7:       return 7'b0001111;
         8:       return 7'b0000000;
         default: return 7'b0000100;
      endcase
   endfunction

   task automatic show(input logic [3:0] an, input logic [6:0] seg, input int cycles);
      @(posedge intClk);
      #1;
      anIn  = an;
      segIn = seg;
      repeat (cycles - 1) @(posedge intClk);
   endtask

   // One refresh pass AN0..AN3, 20 cycles per digit, then 20 dark cycles.
   task automatic frame(input int d3, input int d2, input int d1, input int d0);
      show(A0, seg_of(d0), 20);
      show(A1, seg_of(d1), 20);
      show(A2, seg_of(d2), 20);
      show(A3, seg_of(d3), 20);
      show(A_DARK, S_DARK, 20);
   endtask

   task automatic wait_timeout(input string tag);
      int start;
      int i;
      start = n_to;
      i = 0;
      while (i < 1000 && n_to == start) begin
         @(posedge intClk);
         i++;
      end
      check(tag, 32'(n_to - start), 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, expected finish before 1000000");
      $fatal(1);
   end

   initial begin
      int v0, s0, a0, t0;
      int exp_step;

      // Reset state
      reset = 1'b1;
      anIn  = A_DARK;
      segIn = S_DARK;
      repeat (3) @(negedge intClk);
      check("rst_value", 32'(value), 32'd0);
      check("rst_bcd", 32'(digitsBcd), 32'd0);
      check("rst_valid", 32'(valid), 32'd0);
      check("rst_segerr", 32'(segError), 32'd0);
      check("rst_anerr", 32'(anError), 32'd0);
      check("rst_timeout", 32'(timeout), 32'd0);
      @(posedge intClk);
      #1;
      reset = 1'b0;
      show(A_DARK, S_DARK, 20);

      // Basic frame 1234
      v0 = n_valid;
      frame(1, 2, 3, 4);
      check("f1234_valid_cnt", 32'(n_valid - v0), 32'd1);
      check("f1234_value", 32'(value), 32'd1234);
      check("f1234_bcd", 32'(digitsBcd), 32'h1234);
      check("f1234_no_err", 32'(n_seg + n_an), 32'd0);

      // Repeated refreshes, then 9999
      exp_step = ONCHANGE ? 0 : 1;
      v0 = n_valid;
      frame(1, 2, 3, 4);
      check("rep1_valid_cnt", 32'(n_valid - v0), 32'(exp_step));
      frame(1, 2, 3, 4);
      check("rep2_valid_cnt", 32'(n_valid - v0), 32'(2 * exp_step));
      frame(9, 9, 9, 9);
      check("f9999_valid_cnt", 32'(n_valid - v0), 32'(2 * exp_step + 1));
      check("f9999_value", 32'(value), 32'd9999);
      check("f9999_bcd", 32'(digitsBcd), 32'h9999);

      // Short holds never capture; the frame timer then expires
      v0 = n_valid;
      s0 = n_seg;
      a0 = n_an;
      t0 = n_to;
      for (int r = 0; r < 2; r++) begin
         show(A0, seg_of(1), 5);
         show(A1, seg_of(2), 5);
         show(A2, seg_of(3), 5);
         show(A3, seg_of(4), 5);
      end
      show(A_DARK, S_DARK, 1);
      wait_timeout("short_timeout_seen");
      repeat (5) @(posedge intClk);
      check("short_timeout_pulse", 32'(n_to - t0), 32'd1);
      check("short_no_valid", 32'(n_valid - v0), 32'd0);
      check("short_no_err", 32'((n_seg - s0) + (n_an - a0)), 32'd0);
      check("short_value_held", 32'(value), 32'd9999);

      // Illegal segments on AN2 drop the partial frame
      v0 = n_valid;
      s0 = n_seg;
      show(A0, seg_of(5), 20);
      show(A1, seg_of(6), 20);
      show(A2, S_DARK, 20);
      show(A2, seg_of(7), 20);
      show(A3, seg_of(8), 20);
      show(A_DARK, S_DARK, 20);
      check("segerr_cnt", 32'(n_seg - s0), 32'd1);
      check("segerr_no_valid", 32'(n_valid - v0), 32'd0);
      show(A0, seg_of(5), 20);
      show(A1, seg_of(6), 20);
      show(A_DARK, S_DARK, 20);
      check("segerr_refill_valid", 32'(n_valid - v0), 32'd1);
      check("segerr_refill_value", 32'(value), 32'd8765);
      check("segerr_refill_bcd", 32'(digitsBcd), 32'h8765);

      // Two anodes low drops the partial frame
      v0 = n_valid;
      a0 = n_an;
      s0 = n_seg;
      show(A0, seg_of(1), 20);
      show(A1, seg_of(2), 20);
      show(A2, seg_of(3), 20);
      show(A_BAD, seg_of(0), 20);
      show(A3, seg_of(4), 20);
      show(A_DARK, S_DARK, 20);
      check("anerr_cnt", 32'(n_an - a0), 32'd1);
      check("anerr_no_valid", 32'(n_valid - v0), 32'd0);
      check("anerr_no_segerr", 32'(n_seg - s0), 32'd0);
      check("anerr_value_held", 32'(value), 32'd8765);

      // Reset after three digits discards them and clears outputs at once
      show(A0, seg_of(9), 20);
      show(A1, seg_of(9), 20);
      show(A2, seg_of(9), 20);
      reset = 1'b1;
      #1;
      check("midrst_value", 32'(value), 32'd0);
      check("midrst_bcd", 32'(digitsBcd), 32'd0);
      check("midrst_valid", 32'(valid), 32'd0);
      anIn  = A_DARK;
      segIn = S_DARK;
      repeat (3) @(posedge intClk);
      #1;
      reset = 1'b0;
      show(A_DARK, S_DARK, 20);
      v0 = n_valid;
      show(A3, seg_of(0), 20);
      show(A_DARK, S_DARK, 20);
      check("midrst_partial_gone", 32'(n_valid - v0), 32'd0);
      frame(0, 0, 0, 5);
      check("f0005_valid_cnt", 32'(n_valid - v0), 32'd1);
      check("f0005_value", 32'(value), 32'd5);
      check("f0005_bcd", 32'(digitsBcd), 32'h0005);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/seven_seg_capture.md
Name: seven_seg_capture

Overview:
Loopback decoder for the Basys 3 4-digit multiplexed seven-segment interface. It samples the active-low anode and cathode lines, waits for each digit to stay stable, and decodes each segment pattern back to a BCD digit. It assembles a full 4-digit frame and outputs the 0–9999 binary value with a valid strobe. It lets the display-driver counters self-check on hardware, with outputs routed back through a Pmod.

Parameters:
STABLE_CYCLES, 1000, cycles an {anode, segment} pattern must hold unchanged before it is captured (minimum 2).
FRAME_TIMEOUT, 2000000, cycles allowed between completed frames before a timeout is flagged.

Ports:
intClk  in  1  system clock, 100 MHz.
reset  in  1  asynchronous, active-high reset.
segIn  in  7  cathodes, active-low; MSB = segment A, LSB = segment G.
anIn  in  4  anodes, active-low; bit n = AN n.
value  out  14  last completed frame: d3*1000 + d2*100 + d1*10 + d0.
digitsBcd  out  16  last completed frame as BCD, {d3, d2, d1, d0}.
valid  out  1  one-cycle pulse when value and digitsBcd update.
segError  out  1  one-cycle pulse when a captured pattern is not a legal digit.
anError  out  1  one-cycle pulse when a captured anode pattern is not one-hot-low and not all-ones.
timeout  out  1  one-cycle pulse on frame timeout.

Behaviour:
- Reset values: value = 0, digitsBcd = 0, valid = segError = anError = timeout = 0. All internal counters and the slot mask are 0.
- Synchronizer: 2-flop synchronizer on all 11 inputs. Synchronizer flops reset to all-ones (display dark).
- Stability counter:
  - Clears to 0 whenever the synced 11-bit pattern differs from the previous cycle's synced pattern.
  - Otherwise increments, saturating at STABLE_CYCLES.
  - A capture event fires on the single cycle the counter reaches STABLE_CYCLES-1, i.e. exactly once per stable window.
- Anode decode at capture:
  - 1110 → slot 0, 1101 → slot 1, 1011 → slot 2, 0111 → slot 3.
  - 1111 (blank) → no action.
  - Any other pattern → anError pulse and slot mask cleared.
- Segment decode, pattern → digit:
  - 0000001 → 0, 1001111 → 1, 0010010 → 2, 0000110 → 3, 0001100? no: 1001100 → 4.
  - 0100100 → 5, 0100000 → 6, 0001111 → 7, 0000000 → 8, 0000100 → 9.
  - Any other pattern is illegal → segError pulse, slot mask cleared, digit discarded.
- Slot store:
  - A legal capture writes the digit into its slot register and sets that mask bit.
  - Recapturing an already-set slot overwrites the digit.
- Frame FSM, states COLLECT and EMIT:
  - COLLECT → EMIT on the cycle the mask becomes 4'b1111.
  - EMIT: register digitsBcd, compute value with 14-bit arithmetic (no overflow, max 9999), pulse valid, clear mask, return to COLLECT.
  - valid is asserted on the cycle after the completing capture.
  - value and digitsBcd hold until the next valid.
- Timeout:
  - A cycle counter clears on every valid.
  - On reaching FRAME_TIMEOUT-1: timeout pulse, mask cleared, counter restarts from 0.
- Simultaneous events:
  - Frame completion and timeout on the same cycle: completion wins, and the timeout counter clears.
  - segError or anError suppresses completion in its cycle.
- End-to-end latency from a pin change to capture is 2 + STABLE_CYCLES - 1 cycles.
- Reset mid-frame: partial slots are discarded, and outputs return to their reset values immediately.

Optional Feature:
SEVEN_SEG_CAPTURE_ONCHANGE_EN:
- Defined: valid pulses and outputs update only when the completed frame's BCD differs from the currently held digitsBcd. The first frame after reset always emits, tracked by a first-frame flag. The timeout counter still clears on every completed frame.
- Undefined: every completed frame emits valid.

Decomposition:
- Package seven_seg_pkg holds:
  - the ten active-low segment constants (ZERO..NINE, MSB = A);
  - the four anode select codes (AN0_SEL = 4'b1110 .. AN3_SEL = 4'b0111) and AN_BLANK = 4'b1111;
  - NUM_DIGITS = 4 and a 4-bit BCD digit typedef.
- Sub-module seven_seg_decode: combinational 7-bit pattern → 4-bit digit plus illegal flag, reusable by the display driver's bench.
- Counter widths come from $clog2 of the parameters.

Test Plan:
All scenarios use STABLE_CYCLES = 8 and FRAME_TIMEOUT = 400.
- Drive AN0..AN3 with digits 4, 3, 2, 1, 20 cycles each → one valid pulse, value = 1234, digitsBcd = 16'h1234.
- Repeat the 1234 refresh twice, then digit 9 on all slots → valid pulses with 1234, 1234, then 9999 (with ONCHANGE_EN: 1234 once, then 9999).
- Pattern held only 5 cycles before switching → no capture; after 400 idle cycles → timeout pulse, value unchanged.
- segIn = 1111111 on AN2, held 20 cycles → segError pulse; the next frame requires all four slots again.
- anIn = 1100, held 20 cycles → anError pulse, no valid.
- Assert reset after 3 of 4 digits → all outputs 0; the next full frame 0005 → value = 5.
